// File: rtl/data_mem_requester_pkg.sv
// Shared types and constants for the byte-wide data-memory requester.
// Size encoding matches the datapath's cpu_size field.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DRAIN  = 2'b10,
      DONE   = 2'b11
   } dmr_state_t;

   localparam logic [2:0] BYTES_BYTE = 3'd1;
   localparam logic [2:0] BYTES_HALF = 3'd2;
   localparam logic [2:0] BYTES_WORD = 3'd4;

   // Reserved size yields zero bytes; it is always faulted before any access.
   function automatic logic [2:0] size_bytes(input mem_size_t size);
      case (size)
         SZ_BYTE: size_bytes = BYTES_BYTE;
         SZ_HALF: size_bytes = BYTES_HALF;
         SZ_WORD: size_bytes = BYTES_WORD;
         default: size_bytes = 3'd0;
      endcase
   endfunction

   function automatic logic misaligned(input mem_size_t size, input logic [1:0] low);
      case (size)
         SZ_HALF: misaligned = low[0];
         SZ_WORD: misaligned = |low;
         SZ_RSVD: misaligned = 1'b1;
         default: misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_requester_if.sv
// CPU-side and memory-side bundles of the data-memory requester.
// The datapath masters the CPU bundle; the requester masters the memory bundle.
interface dmr_cpu_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [1:0]  cpu_size;
   logic        cpu_unsigned;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_busy;
   logic        cpu_done;
   logic        cpu_err;
   logic [31:0] cpu_rdata;

   modport master (
      output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
      input  cpu_busy, cpu_done, cpu_err, cpu_rdata
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
      output cpu_busy, cpu_done, cpu_err, cpu_rdata
   );
endinterface

interface dmr_mem_if #(parameter int unsigned ADDR_W = 6);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   modport master (
      output mem_addr, mem_re, mem_we, mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr, mem_re, mem_we, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/data_mem_requester_load_extend.sv
// Sign/zero extension of an assembled right-justified load word.
module load_extend
   import mips_mem_pkg::*;
(
   input  logic [31:0] word,
   input  mem_size_t   size,
   input  logic        is_unsigned,
   output logic [31:0] rdata
);

   always_comb begin
      rdata = word;
      case (size)
         SZ_BYTE: rdata = {{24{~is_unsigned & word[7]}}, word[7:0]};
         SZ_HALF: rdata = {{16{~is_unsigned & word[15]}}, word[15:0]};
         default: rdata = word;
      endcase
   end

endmodule

// File: rtl/data_mem_requester.sv
// Sequences one CPU load/store into big-endian byte accesses on the data memory,
// assembling and extending load data and faulting bad size/alignment/range.
module data_mem_requester
   import mips_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 6
) (
   input  logic      clk,
   input  logic      rst_n,
   dmr_cpu_if.slave  cpu,
   dmr_mem_if.master mem
);

   dmr_state_t        state, state_nxt;
   logic              we_q;
   logic              uns_q;
   mem_size_t         size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        cnt_q;
   logic [31:0]       wbuf_q;
   logic [23:0]       shift_q;
   logic              rd_pend_q;
   logic              err_q;
   logic [31:0]       rdata_q;

   logic              accept;
   logic              fault;
   logic              last;
   logic              rd_strobe;
   logic              wr_strobe;
   logic [2:0]        req_bytes;
   logic [5:0]        wshift;
   logic [31:0]       ext_rdata;

   assign accept    = (state == IDLE) && cpu.cpu_req;
   assign req_bytes = size_bytes(mem_size_t'(cpu.cpu_size));
   assign fault     = misaligned(mem_size_t'(cpu.cpu_size), cpu.cpu_addr[1:0])
                      || ((cpu.cpu_addr >> ADDR_W) != 32'd0);
   // Left-justify store data so the MSB of the N stored bytes leaves first.
   assign wshift    = {3'd4 - req_bytes, 3'b000};
   assign last      = ({1'b0, cnt_q} == (size_bytes(size_q) - 3'd1));

   assign rd_strobe = (state == ACCESS) && !we_q;
   assign wr_strobe = (state == ACCESS) && we_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = fault ? DONE : ACCESS;
         ACCESS:  if (last) state_nxt = we_q ? DONE : DRAIN;
         DRAIN:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Final load byte arrives during DRAIN; merge it directly instead of waiting a cycle.
   load_extend u_load_extend (
      .word        ({shift_q, mem.mem_rdata}),
      .size        (size_q),
      .is_unsigned (uns_q),
      .rdata       (ext_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q      <= 1'b0;
         uns_q     <= 1'b0;
         size_q    <= SZ_BYTE;
         addr_q    <= '0;
         cnt_q     <= '0;
         wbuf_q    <= '0;
         shift_q   <= '0;
         rd_pend_q <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         rd_pend_q <= rd_strobe;
         if (rd_pend_q) begin
            shift_q <= {shift_q[15:0], mem.mem_rdata};
         end
         if (accept) begin
            we_q    <= cpu.cpu_we;
            uns_q   <= cpu.cpu_unsigned;
            size_q  <= mem_size_t'(cpu.cpu_size);
            addr_q  <= cpu.cpu_addr[ADDR_W-1:0];
            cnt_q   <= '0;
            wbuf_q  <= cpu.cpu_wdata << wshift;
            shift_q <= '0;
            err_q   <= fault;
            if (fault) begin
               rdata_q <= '0;
            end
         end
         if (state == ACCESS) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q + 1'b1;
            wbuf_q <= {wbuf_q[23:0], 8'h00};
            if (last && we_q) begin
               rdata_q <= '0;
            end
         end
         if (state == DRAIN) begin
            rdata_q <= ext_rdata;
         end
      end
   end

   assign cpu.cpu_busy  = (state != IDLE);
   assign cpu.cpu_done  = (state == DONE);
   assign cpu.cpu_err   = (state == DONE) && err_q;
   assign cpu.cpu_rdata = rdata_q;

   assign mem.mem_addr  = addr_q;
   assign mem.mem_re    = rd_strobe;
   assign mem.mem_we    = wr_strobe;
   assign mem.mem_wdata = wr_strobe ? wbuf_q[31:24] : 8'h00;

endmodule

// File: tb/tb_data_mem_requester.sv
// Directed bench for data_mem_requester with a 64-byte, 1-cycle-latency memory model.
module tb_data_mem_requester;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmr_cpu_if cpu ();
   dmr_mem_if #(.ADDR_W(6)) mem ();

   data_mem_requester #(.ADDR_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cpu   (cpu),
      .mem   (mem)
   );

   logic [7:0] mem_arr [64];

   always @(posedge clk) begin
      if (mem.mem_we) mem_arr[mem.mem_addr] <= mem.mem_wdata;
      if (mem.mem_re) mem.mem_rdata <= mem_arr[mem.mem_addr];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic txn(input string tag, input bit we, input logic [1:0] size, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input bit exp_err, input bit chk_rdata, input logic [31:0] exp_rdata);
      int n, lat_exp, k, strobes;
      bit seen;
      n       = exp_err ? 0 : (size == 2'b00 ? 1 : (size == 2'b01 ? 2 : 4));
      lat_exp = exp_err ? 1 : (we ? n + 1 : n + 2);
      @(negedge clk);
      cpu.cpu_req      = 1'b1;
      cpu.cpu_we       = we;
      cpu.cpu_size     = size;
      cpu.cpu_unsigned = uns;
      cpu.cpu_addr     = addr;
      cpu.cpu_wdata    = wdata;
      @(posedge clk);
      #1;
      // scramble inputs after accept: the transaction must use latched values
      cpu.cpu_req   = 1'b0;
      cpu.cpu_we    = ~we;
      cpu.cpu_size  = 2'b11;
      cpu.cpu_addr  = 32'hFFFF_FFFF;
      cpu.cpu_wdata = 32'h0;
      k = 1;
      strobes = 0;
      seen = 1'b0;
      while (k <= 20 && !seen) begin
         check({tag, " busy"}, 32'(cpu.cpu_busy), 32'd1);
         if (mem.mem_re || mem.mem_we) begin
            strobes++;
            check({tag, " addr"}, 32'(mem.mem_addr), (addr + 32'(k) - 32'd1) & 32'h3F);
            check({tag, " dir"}, 32'(mem.mem_we), 32'(we));
            if (we) check({tag, " wdata"}, 32'(mem.mem_wdata), (wdata >> (8 * (n - k))) & 32'hFF);
         end
         if (cpu.cpu_done) seen = 1'b1;
         else begin
            @(posedge clk);
            #1;
            k++;
         end
      end
      check({tag, " done_lat"}, seen ? 32'(k) : 32'd99, 32'(lat_exp));
      check({tag, " err"}, 32'(cpu.cpu_err), 32'(exp_err));
      check({tag, " strobes"}, 32'(strobes), 32'(n));
      if (chk_rdata) check({tag, " rdata"}, cpu.cpu_rdata, exp_rdata);
      @(posedge clk);
      #1;
      check({tag, " idle_busy"}, 32'(cpu.cpu_busy), 32'd0);
      check({tag, " idle_done"}, 32'(cpu.cpu_done), 32'd0);
   endtask

   initial begin
      int dones, reads, k;
      cpu.cpu_req = 1'b0; cpu.cpu_we = 1'b0; cpu.cpu_size = 2'b00;
      cpu.cpu_unsigned = 1'b0; cpu.cpu_addr = '0; cpu.cpu_wdata = '0;
      for (int i = 0; i < 64; i++) mem_arr[i] = 8'h00;
      mem_arr[0] = 8'hDE; mem_arr[1] = 8'hAD; mem_arr[2] = 8'hBE; mem_arr[3] = 8'hEF;

      repeat (3) @(posedge clk);
      #1;
      check("rst busy",  32'(cpu.cpu_busy), 32'd0);
      check("rst done",  32'(cpu.cpu_done), 32'd0);
      check("rst err",   32'(cpu.cpu_err), 32'd0);
      check("rst rdata", cpu.cpu_rdata, 32'd0);
      check("rst re",    32'(mem.mem_re), 32'd0);
      check("rst we",    32'(mem.mem_we), 32'd0);
      check("rst addr",  32'(mem.mem_addr), 32'd0);
      check("rst wdata", 32'(mem.mem_wdata), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //   tag    we    size   uns   addr     wdata         err   chk   rdata
      txn("lw0",  1'b0, 2'b10, 1'b0, 32'd0,   32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
      txn("lb2",  1'b0, 2'b00, 1'b0, 32'd2,   32'h0,        1'b0, 1'b1, 32'hFFFFFFBE);
      txn("lbu2", 1'b0, 2'b00, 1'b1, 32'd2,   32'h0,        1'b0, 1'b1, 32'h000000BE);
      txn("lh2",  1'b0, 2'b01, 1'b0, 32'd2,   32'h0,        1'b0, 1'b1, 32'hFFFFBEEF);
      txn("lhu0", 1'b0, 2'b01, 1'b1, 32'd0,   32'h0,        1'b0, 1'b1, 32'h0000DEAD);
      txn("sw8",  1'b1, 2'b10, 1'b0, 32'd8,   32'h12345678, 1'b0, 1'b0, 32'h0);
      txn("sb9",  1'b1, 2'b00, 1'b0, 32'd9,   32'hFFFFFFAA, 1'b0, 1'b0, 32'h0);
      txn("lw8",  1'b0, 2'b10, 1'b0, 32'd8,   32'h0,        1'b0, 1'b1, 32'h12AA5678);
      txn("flw6", 1'b0, 2'b10, 1'b0, 32'd6,   32'h0,        1'b1, 1'b1, 32'h0);
      txn("flh1", 1'b0, 2'b01, 1'b0, 32'd1,   32'h0,        1'b1, 1'b1, 32'h0);
      txn("lb8",  1'b0, 2'b00, 1'b0, 32'd8,   32'h0,        1'b0, 1'b1, 32'h00000012);
      txn("fsz3", 1'b0, 2'b11, 1'b0, 32'd0,   32'h0,        1'b1, 1'b1, 32'h0);
      txn("flhi", 1'b0, 2'b10, 1'b0, 32'h40,  32'h0,        1'b1, 1'b1, 32'h0);
      txn("fsw5", 1'b1, 2'b10, 1'b0, 32'd5,   32'hCAFEF00D, 1'b1, 1'b1, 32'h0);
      txn("lw8b", 1'b0, 2'b10, 1'b0, 32'd8,   32'h0,        1'b0, 1'b1, 32'h12AA5678);

      // asynchronous reset in the middle of a load
      @(negedge clk);
      cpu.cpu_req = 1'b1; cpu.cpu_we = 1'b0; cpu.cpu_size = 2'b10; cpu.cpu_addr = 32'd0;
      @(posedge clk);
      #1;
      cpu.cpu_req = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      check("arst pre_re", 32'(mem.mem_re), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst re",   32'(mem.mem_re), 32'd0);
      check("arst busy", 32'(cpu.cpu_busy), 32'd0);
      check("arst done", 32'(cpu.cpu_done), 32'd0);
      dones = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (cpu.cpu_done) dones++;
      end
      check("arst no_done", 32'(dones), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      txn("lw0r", 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);

      // request held high: one transaction, idle cycle, then next accept
      @(negedge clk);
      cpu.cpu_req = 1'b1; cpu.cpu_we = 1'b0; cpu.cpu_size = 2'b10; cpu.cpu_addr = 32'd0;
      @(posedge clk);
      #1;
      reads = 0;
      k = 1;
      while (k <= 20 && !cpu.cpu_done) begin
         if (mem.mem_re) reads++;
         @(posedge clk);
         #1;
         k++;
      end
      check("hold lat",   32'(k), 32'd6);
      check("hold reads", 32'(reads), 32'd4);
      check("hold busy_done", 32'(cpu.cpu_busy), 32'd1);
      @(posedge clk);
      #1;
      check("hold idle", 32'(cpu.cpu_busy), 32'd0);
      @(posedge clk);
      #1;
      check("hold reaccept", 32'(cpu.cpu_busy), 32'd1);
      cpu.cpu_req = 1'b0;
      k = 1;
      while (k <= 20 && !cpu.cpu_done) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("hold2 lat",   32'(k), 32'd6);
      check("hold2 rdata", cpu.cpu_rdata, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      check("hold2 idle", 32'(cpu.cpu_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
